// File: rtl/century_clock_pkg.sv
// Shared types and helpers for the button conditioner and its channels.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package century_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop sync, debouncer, press/auto-repeat FSM (repeat only with BTN_AUTO_REPEAT_EN).
// Latency: combinational pulse DEBOUNCE_CYCLES+1 edges after the first sync flop captures a press.
// Backpressure: none; the pulse is a one-cycle strobe.
module btn_channel
    import century_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    btn_state_e       state_q, state_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    always_comb begin
        sync1_d   = raw_in;
        sync2_d   = sync1_q;
        level_d   = level_q;
        deb_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // The FSM only sits in IDLE while the level is low, so a high level there is a fresh rise.
    always_comb begin
        state_d = state_q;
        pulse   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    pulse   = 1'b1;
                    state_d = ST_HOLD;
`ifdef BTN_AUTO_REPEAT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ST_HOLD: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (hold_cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                    pulse      = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_REPEAT;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
            end
`ifdef BTN_AUTO_REPEAT_EN
            ST_REPEAT: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                    pulse      = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
            state_q   <= ST_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
`ifdef BTN_AUTO_REPEAT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign level = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Up/down button conditioner with mutual exclusion; auto-repeat enabled by BTN_AUTO_REPEAT_EN.
// Latency: registered pulse DEBOUNCE_CYCLES+2 edges after raw capture.
// Backpressure: none; up/down are one-cycle strobes.
module btn_conditioner
    import century_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down
);

    logic up_level, up_pulse;
    logic down_level, down_pulse;
    logic up_q, up_d;
    logic down_q, down_d;

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_up (
        .clk    (clk),
        .rst    (rst),
        .raw_in (btn_up_raw),
        .level  (up_level),
        .pulse  (up_pulse)
    );

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_down (
        .clk    (clk),
        .rst    (rst),
        .raw_in (btn_down_raw),
        .level  (down_level),
        .pulse  (down_pulse)
    );

    // A pulse only occurs while its own level is high, so masking by the other level excludes both.
    always_comb begin
        up_d   = up_pulse & ~down_level;
        down_d = down_pulse & ~up_level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= up_d;
            down_q <= down_d;
        end
    end

    assign up   = up_q;
    assign down = down_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: a timeline model predicts every pulse edge; a monitor checks DUT strobes.
module tb_btn_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int N  = 8192;

    typedef struct {
        int   t;
        logic u;
        logic d;
    } exp_t;

    logic clk, rst, btn_up_raw, btn_down_raw, up, down;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .up           (up),
        .down         (down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = -1;
    exp_t exp_q[$];

    // Model timeline: cap = raw value captured at edge t, lvl = debounced level after edge t.
    bit cu[N], cd[N], lu[N], ld[N];
    int ru = -1, rdn = -1;

    // Level flips at edge t when the D captures feeding comparisons at edges t-D+1..t all differ.
    function automatic bit window_differs(input int t, input bit lvl, input bit is_up);
        for (int i = t - D - 1; i <= t - 2; i++) begin
            if (i < 0) return 1'b0;
            if ((is_up ? cu[i] : cd[i]) == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Pulse schedule relative to the edge r where the level rose.
    function automatic bit sched(input int p, input int r);
        int dd;
        dd = p - r - 1;
        if (dd == 0) return 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
        if (dd >= RD && ((dd - RD) % RP) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int t;
        bit pu, pd, eu, ed;
        exp_t e;
        cyc = cyc + 1;
        t = cyc;
        if (t < N) begin
            pu = (t > 0) ? lu[t-1] : 1'b0;
            pd = (t > 0) ? ld[t-1] : 1'b0;
            if (rst !== 1'b1 && t > 0) begin
                eu = pu && !pd && sched(t, ru);
                ed = pd && !pu && sched(t, rdn);
                if (eu || ed) begin
                    e.t = t; e.u = eu; e.d = ed;
                    exp_q.push_back(e);
                end
            end
            cu[t] = (btn_up_raw === 1'b1);
            cd[t] = (btn_down_raw === 1'b1);
            if (rst === 1'b1) begin
                cu[t] = 1'b0; cd[t] = 1'b0;
                if (t > 0) begin cu[t-1] = 1'b0; cd[t-1] = 1'b0; end
                lu[t] = 1'b0; ld[t] = 1'b0;
            end else begin
                lu[t] = window_differs(t, pu, 1'b1) ? ~pu : pu;
                ld[t] = window_differs(t, pd, 1'b0) ? ~pd : pd;
            end
            if (lu[t] && !pu) ru = t;
            if (ld[t] && !pd) rdn = t;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
            e = exp_q.pop_front();
            tests++; fails++;
            $display("FAIL missed_pulse: expected up=%0b down=%0b at edge %0d, got no pulse", e.u, e.d, e.t);
        end
        if (up === 1'b1 || down === 1'b1) begin
            tests++;
            if (up === 1'b1 && down === 1'b1) begin
                fails++;
                $display("FAIL mutex: up=1 and down=1 together at edge %0d, required at most one", cyc);
            end
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: up=%0b down=%0b at edge %0d, required no pulse", up, down, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.u !== up || e.d !== down) begin
                    fails++;
                    $display("FAIL pulse: got up=%0b down=%0b at edge %0d, required up=%0b down=%0b at edge %0d",
                             up, down, cyc, e.u, e.d, e.t);
                end
            end
        end
    end

    task automatic drive(input logic u, input logic d, input int n);
        btn_up_raw   = u;
        btn_down_raw = d;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        btn_up_raw = 1'b0;
        btn_down_raw = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (up !== 1'b0 || down !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: up=%0b down=%0b, required 0 0", up, down);
        end
        rst = 1'b0;
        drive(0, 0, 5);
        // clean press
        drive(1, 0, 5);
        drive(0, 0, 15);
        // bounce shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 2);
            drive(0, 0, 2);
        end
        drive(0, 0, 15);
        // long hold on down
        drive(0, 1, 30);
        drive(0, 0, 20);
        // both pressed, then down released
        drive(1, 1, 30);
        drive(1, 0, 20);
        drive(0, 0, 20);
        // reset during auto-repeat with up still held
        drive(1, 0, 25);
        rst = 1'b1;
        drive(1, 0, 1);
        rst = 1'b0;
        drive(1, 0, 15);
        drive(0, 0, 20);
        // random segments with occasional resets
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 25)));
        end
        drive(0, 0, 30);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected pulses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
